// File: rtl/branch_resolve_pred.sv
// EX-stage branch resolution with 2-bit BHT training and stats.
// Optional BHT storage enabled by defining BRANCH_PRED_EN.
module branch_resolve_pred #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   lk_pc,
  output logic              lk_pred,
  input  logic              ex_valid,
  input  logic [2:0]        ex_op,
  input  logic [DATA_W-1:0] ex_rs,
  input  logic [DATA_W-1:0] ex_rt,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_pred,
  input  logic              ex_stall,
  input  logic              stat_clr,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic [PC_W-1:0]   res_pc,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispred
);

  logic              w_accept;
  logic              w_op_ok;
  logic              w_taken;
  logic              w_pred;
  logic              w_mis;
  logic              w_rs_neg;
  logic              w_rs_zero;
  logic              w_eq;
  logic              w_upd;
  logic              w_unused_lk;

  logic              r_valid;
  logic              r_taken;
  logic              r_mis;
  logic [PC_W-1:0]   r_pc;
  logic [CNT_W-1:0]  r_br;
  logic [CNT_W-1:0]  r_mp;

  assign w_accept  = ex_valid & ~ex_stall;
  assign w_rs_neg  = ex_rs[DATA_W-1];
  assign w_rs_zero = (ex_rs == '0);
  assign w_eq      = (ex_rs == ex_rt);
  assign w_upd     = w_accept & w_op_ok;

  // Evaluate the branch condition; reserved ops never take.
  always_comb begin
    w_taken = 1'b0;
    w_op_ok = 1'b1;
    unique case (ex_op)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = ~w_eq;
      3'b010:  w_taken = w_rs_neg | w_rs_zero;
      3'b011:  w_taken = ~w_rs_neg & ~w_rs_zero;
      3'b100:  w_taken = w_rs_neg;
      3'b101:  w_taken = ~w_rs_neg;
      default: w_op_ok = 1'b0;
    endcase
  end

`ifdef BRANCH_PRED_EN
  localparam int NENT = 1 << BHT_IDX_W;

  logic [1:0]           r_bht [NENT];
  logic [BHT_IDX_W-1:0] w_lk_idx;
  logic [BHT_IDX_W-1:0] w_ex_idx;

  assign w_lk_idx = lk_pc[BHT_IDX_W+1:2];
  assign w_ex_idx = ex_pc[BHT_IDX_W+1:2];
  assign lk_pred  = r_bht[w_lk_idx][1];
  assign w_pred   = ex_pred;
  assign w_unused_lk =
    ^{lk_pc[PC_W-1:BHT_IDX_W+2], lk_pc[1:0]};

  // Train the saturating counter of the resolved branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_upd) begin
      if (w_taken && r_bht[w_ex_idx] != 2'b11) begin
        r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'd1;
      end else if (!w_taken && r_bht[w_ex_idx] != 2'b00) begin
        r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'd1;
      end
    end
  end
`else
  assign lk_pred     = 1'b0;
  assign w_pred      = 1'b0;
  assign w_unused_lk = ^lk_pc;
`endif

  assign w_mis = w_op_ok ? (w_taken ^ w_pred) : ex_pred;

  // Register the resolution; payload holds when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_taken <= 1'b0;
      r_mis   <= 1'b0;
      r_pc    <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_taken <= w_taken;
        r_mis   <= w_mis;
        r_pc    <= ex_pc;
      end
    end
  end

  // Saturating statistics; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br <= '0;
      r_mp <= '0;
    end else if (stat_clr) begin
      r_br <= '0;
      r_mp <= '0;
    end else if (w_upd) begin
      if (r_br != {CNT_W{1'b1}}) begin
        r_br <= r_br + 1'b1;
      end
      if (w_mis && r_mp != {CNT_W{1'b1}}) begin
        r_mp <= r_mp + 1'b1;
      end
    end
  end

  assign res_valid      = r_valid;
  assign res_taken      = r_taken;
  assign res_mispredict = r_mis;
  assign res_pc         = r_pc;
  assign stat_branches  = r_br;
  assign stat_mispred   = r_mp;

endmodule

// File: tb/tb_branch_resolve_pred.sv
// Bench for branch_resolve_pred: reference model plus directed pins.
// Tracks BRANCH_PRED_EN the same way the design does.
module tb_branch_resolve_pred;

  localparam int CW = 4;
  localparam int SMAX = (1 << CW) - 1;
`ifdef BRANCH_PRED_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   lk_pc = '0;
  logic          lk_pred;
  logic          ex_valid = 1'b0;
  logic [2:0]    ex_op = '0;
  logic [31:0]   ex_rs = '0;
  logic [31:0]   ex_rt = '0;
  logic [31:0]   ex_pc = '0;
  logic          ex_pred = 1'b0;
  logic          ex_stall = 1'b0;
  logic          stat_clr = 1'b0;
  logic          res_valid;
  logic          res_taken;
  logic          res_mispredict;
  logic [31:0]   res_pc;
  logic [CW-1:0] stat_branches;
  logic [CW-1:0] stat_mispred;

  branch_resolve_pred #(
    .DATA_W(32), .PC_W(32), .BHT_IDX_W(6), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_pc(lk_pc), .lk_pred(lk_pred),
    .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_pc(ex_pc), .ex_pred(ex_pred),
    .ex_stall(ex_stall), .stat_clr(stat_clr),
    .res_valid(res_valid), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .res_pc(res_pc),
    .stat_branches(stat_branches),
    .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: counters as plain integers 0..3.
  int          m_bht [64];
  bit          m_valid = 0;
  bit          m_taken = 0;
  bit          m_mis = 0;
  logic [31:0] m_pc = '0;
  int          m_br = 0;
  int          m_mp = 0;
  bit          t;
  bit          p;
  int          idx;

  initial begin
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
  end

  function automatic bit cond(logic [2:0] op, logic [31:0] rs,
                              logic [31:0] rt);
    case (op)
      3'd0: return rs == rt;
      3'd1: return rs != rt;
      3'd2: return $signed(rs) <= 0;
      3'd3: return $signed(rs) > 0;
      3'd4: return $signed(rs) < 0;
      3'd5: return $signed(rs) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge rst_n) begin
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_valid = 0; m_taken = 0; m_mis = 0;
    m_pc = '0; m_br = 0; m_mp = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_valid = ex_valid && !ex_stall;
      if (m_valid) begin
        m_pc = ex_pc;
        if (ex_op < 3'd6) begin
          t = cond(ex_op, ex_rs, ex_rt);
          p = PE ? ex_pred : 1'b0;
          m_taken = t;
          m_mis = (t != p);
          idx = int'(ex_pc[7:2]);
          if (t) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
          else   m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
          if (!stat_clr) begin
            if (m_br < SMAX) m_br++;
            if (m_mis && m_mp < SMAX) m_mp++;
          end
        end else begin
          m_taken = 0;
          m_mis = ex_pred;
        end
      end
      if (stat_clr) begin
        m_br = 0;
        m_mp = 0;
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
    chk("res_taken", {31'd0, res_taken}, {31'd0, m_taken});
    chk("res_mis", {31'd0, res_mispredict}, {31'd0, m_mis});
    chk("res_pc", res_pc, m_pc);
    chk("stat_br", 32'(stat_branches), m_br);
    chk("stat_mp", 32'(stat_mispred), m_mp);
    chk("lk_pred", {31'd0, lk_pred},
        {31'd0, PE && (m_bht[int'(lk_pc[7:2])] >= 2)});
  end

  task automatic cyc(bit v, bit st, logic [2:0] op,
                     logic [31:0] rs, logic [31:0] rt,
                     logic [31:0] pc, bit pr, bit clr);
    ex_valid = v; ex_stall = st; ex_op = op;
    ex_rs = rs; ex_rt = rt; ex_pc = pc;
    ex_pred = pr; stat_clr = clr; lk_pc = pc;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(logic [31:0] pc);
    cyc(0, 0, 3'd0, 0, 0, pc, 0, 0);
  endtask

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_0020;
  localparam logic [31:0] PC = 32'h0040_0040;
  localparam logic [31:0] PD = 32'h0040_0080;
  localparam logic [31:0] NEG = 32'hFFFF_FFFF;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(32'h0040_0000);
    chk("rst_valid", {31'd0, res_valid}, 0);
    chk("rst_br", 32'(stat_branches), 0);
    chk("rst_mp", 32'(stat_mispred), 0);
    chk("rst_lk", {31'd0, lk_pred}, 0);

    cyc(1, 0, 3'd0, 32'h1234, 32'h1234, PA, 0, 0);
    chk("beq_valid", {31'd0, res_valid}, 1);
    chk("beq_taken", {31'd0, res_taken}, 1);
    chk("beq_mis", {31'd0, res_mispredict}, 1);
    chk("beq_pc", res_pc, PA);
    chk("beq_br", 32'(stat_branches), 1);
    chk("beq_mp", 32'(stat_mispred), 1);
    chk("beq_lk", {31'd0, lk_pred}, {31'd0, PE});

    repeat (4) cyc(1, 0, 3'd1, 1, 2, PB, 0, 0);
    chk("sat_hi_lk", {31'd0, lk_pred}, {31'd0, PE});
    cyc(1, 0, 3'd1, 5, 5, PB, 1, 0);
    chk("sat_10_lk", {31'd0, lk_pred}, {31'd0, PE});
    chk("bne_nt", {31'd0, res_taken}, 0);
    repeat (2) cyc(1, 0, 3'd1, 5, 5, PB, 1, 0);
    chk("sat_00_lk", {31'd0, lk_pred}, 0);
    cyc(1, 0, 3'd1, 5, 5, PB, 0, 0);
    chk("sat_lo_lk", {31'd0, lk_pred}, 0);

    cyc(1, 0, 3'd4, NEG, 0, PC, 0, 0);
    chk("bltz_neg", {31'd0, res_taken}, 1);
    cyc(1, 0, 3'd5, NEG, 0, PC, 0, 0);
    chk("bgez_neg", {31'd0, res_taken}, 0);
    cyc(1, 0, 3'd2, NEG, 0, PC, 0, 0);
    chk("blez_neg", {31'd0, res_taken}, 1);
    cyc(1, 0, 3'd3, NEG, 0, PC, 0, 0);
    chk("bgtz_neg", {31'd0, res_taken}, 0);
    cyc(1, 0, 3'd2, 0, NEG, PC, 0, 0);
    chk("blez_0", {31'd0, res_taken}, 1);
    cyc(1, 0, 3'd5, 0, NEG, PC, 0, 0);
    chk("bgez_0", {31'd0, res_taken}, 1);
    cyc(1, 0, 3'd4, 0, NEG, PC, 0, 0);
    chk("bltz_0", {31'd0, res_taken}, 0);
    cyc(1, 0, 3'd3, 0, NEG, PC, 0, 0);
    chk("bgtz_0", {31'd0, res_taken}, 0);
    chk("br_sat_early", 32'(stat_branches), 15);

    cyc(0, 0, 3'd0, 0, 0, PB, 0, 1);
    chk("clr_br", 32'(stat_branches), 0);
    chk("clr_mp", 32'(stat_mispred), 0);
    cyc(1, 1, 3'd0, 7, 7, PB, 0, 0);
    chk("stall_valid", {31'd0, res_valid}, 0);
    chk("stall_br", 32'(stat_branches), 0);
    chk("stall_lk", {31'd0, lk_pred}, 0);
    cyc(1, 0, 3'd7, 7, 7, PB, 1, 0);
    chk("rsv_valid", {31'd0, res_valid}, 1);
    chk("rsv_taken", {31'd0, res_taken}, 0);
    chk("rsv_mis", {31'd0, res_mispredict}, 1);
    chk("rsv_br", 32'(stat_branches), 0);
    chk("rsv_lk", {31'd0, lk_pred}, 0);

    repeat (17) cyc(1, 0, 3'd0, 9, 9, PD, 0, 0);
    chk("sat_br", 32'(stat_branches), 15);
    chk("sat_mp", 32'(stat_mispred), 15);
    cyc(1, 0, 3'd0, 9, 9, PD, 0, 1);
    chk("clr_acc_br", 32'(stat_branches), 0);
    chk("clr_acc_mp", 32'(stat_mispred), 0);
    chk("clr_acc_valid", {31'd0, res_valid}, 1);

    ex_valid = 1'b1; ex_stall = 1'b0; ex_op = 3'd0;
    ex_pc = PA; lk_pc = PA;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, res_valid}, 0);
    chk("mid_rst_pc", res_pc, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(PA);
    chk("post_rst_lk", {31'd0, lk_pred}, 0);
    chk("post_rst_valid", {31'd0, res_valid}, 0);
    idle(PA);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_pred.md
Name: branch_resolve_pred

Overview:
- Parametrised branch resolution unit for the MIPS pipeline, sitting in EX.
- Evaluates six MIPS conditional-branch conditions on register operands and compares the outcome with the prediction carried from IF.
- Trains a 2-bit saturating branch history table (BHT) and reports a registered resolution result (taken/mispredict) to the PC-select mux and the flush logic.
- Fetch-side lookup is combinational; resolution and table update are sequential; saturating statistics counters are kept for performance measurement.

Parameters:
DATA_W, 32, operand width (rs/rt)
PC_W, 32, program counter width
BHT_IDX_W, 6, log2 of BHT entries (64 entries)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
lk_pc  in  PC_W  fetch PC for prediction lookup
lk_pred  out  1  predicted taken for lk_pc (combinational)
ex_valid  in  1  branch present in EX this cycle
ex_op  in  3  condition: 000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ, 110/111 reserved
ex_rs  in  DATA_W  first operand
ex_rt  in  DATA_W  second operand (BEQ/BNE only)
ex_pc  in  PC_W  PC of the branch in EX
ex_pred  in  1  prediction made in IF for this branch
ex_stall  in  1  pipeline stall; EX content not consumed
stat_clr  in  1  synchronous clear of statistics counters
res_valid  out  1  registered: resolution result valid
res_taken  out  1  registered: branch taken
res_mispredict  out  1  registered: res_taken != ex_pred
res_pc  out  PC_W  registered: echo of ex_pc
stat_branches  out  CNT_W  resolved-branch count
stat_mispred  out  CNT_W  mispredict count

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - res_valid, res_taken, res_mispredict = 0; res_pc = 0.
  - All BHT entries = 2'b01 (weakly not-taken).
  - stat_branches, stat_mispred = 0.
  - Reset asserted mid-operation discards any in-flight resolution immediately.
- BHT index: pc[BHT_IDX_W+1:2]; bits [1:0] are ignored.
- Lookup: lk_pred = MSB of BHT[index(lk_pc)], combinational with no latency.
- Conditions:
  - BEQ: rs==rt. BNE: rs!=rt.
  - BLEZ, BGTZ, BLTZ, BGEZ compare signed rs against zero.
  - rt is ignored for the zero-compare ops.
- Accept: accept = ex_valid & !ex_stall.
- Latency: on an accept, the res_* registers are loaded on that edge and res_valid=1 for exactly one cycle after.
  - If there is no accept, res_valid=0 next cycle and res_taken/res_mispredict/res_pc hold their previous values.
- Reserved op (110/111) on accept:
  - res_taken=0, res_mispredict=ex_pred, res_valid=1.
  - No BHT update; statistics not incremented.
- BHT update on accept with a valid op:
  - The counter at index(ex_pc) increments if taken and decrements if not taken.
  - It saturates at 2'b11 and 2'b00; no wrap.
- Same-cycle lookup and update of the same index: lk_pred reflects the pre-update value (read-before-write). The new value is visible from the next cycle.
- Statistics:
  - On accept with a valid op, stat_branches +1; stat_mispred +1 if mispredicted.
  - Both saturate at all-ones; no wrap.
  - stat_clr has priority over increment; cleared value is 0 next cycle.
- ex_stall=1 blocks accept regardless of ex_valid: no BHT, statistics or result change except res_valid=0.

Optional Feature:
BRANCH_PRED_EN
- Defined: BHT present, behaviour as above.
- Undefined:
  - No BHT storage.
  - lk_pred is constant 0 (static not-taken).
  - res_mispredict = res_taken for valid ops; ex_pred is ignored.
  - Statistics and resolution logic unchanged.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high -> res_valid=0, stat_*=0, lk_pred=0 for lk_pc=0x00400000.
- BEQ taken with default prediction: ex_op=000, rs=rt=0x1234, ex_pred=0, ex_pc=0x00400010 -> next cycle res_valid=1, res_taken=1, res_mispredict=1, res_pc=0x00400010, stat_branches=1, stat_mispred=1. lk_pc=0x00400010 then gives lk_pred=1 (counter 10).
- Saturation: 4 taken BNE at the same PC (rs=1, rt=2) -> counter reaches 11 and stays; then 1 not-taken -> 10, lk_pred still 1; 2 more not-taken -> 00, then 00 again on a further not-taken.
- Signed compares: rs=0xFFFFFFFF -> BLTZ taken, BGEZ not, BLEZ taken, BGTZ not; rs=0 -> BLEZ and BGEZ taken, BLTZ and BGTZ not.
- Stall and reserved op:
  - ex_valid=1 with ex_stall=1 -> res_valid=0 next cycle, stat unchanged, BHT unchanged.
  - ex_op=111 with ex_pred=1 -> res_valid=1, res_taken=0, res_mispredict=1, stat unchanged.
- Stat saturation and clear: with CNT_W=4, 17 accepted branches -> stat_branches=15. stat_clr asserted together with an accept -> 0 next cycle.
